// File: rtl/rom_read_arbiter_if.sv
// rom_read_arbiter_if: request/response/ROM bus bundle for the two-port ROM read arbiter
// Ports (slave = arbiter side):
//   req0/1_valid, req0/1_addr  : read requests from requester 0/1
//   req0/1_ready               : request accepted this cycle
//   rsp0/1_valid, rsp0/1_ready : response handshake per requester
//   rsp_data                   : registered read data shared by both requesters
//   rom_addr, rom_data         : combinational ROM read port
//   busy                       : arbiter not idle
interface rom_read_arbiter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
);
    logic                  req0_valid;
    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic                  req0_ready;
    logic                  req1_ready;
    logic                  rsp0_valid;
    logic                  rsp1_valid;
    logic                  rsp0_ready;
    logic                  rsp1_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic                  busy;

    modport slave (
        input  req0_valid, req1_valid, req0_addr, req1_addr, rsp0_ready, rsp1_ready, rom_data,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rom_addr, busy
    );

    modport master (
        output req0_valid, req1_valid, req0_addr, req1_addr, rsp0_ready, rsp1_ready, rom_data,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rom_addr, busy
    );
endinterface

// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter: round-robin arbiter sharing one combinational ROM between two requesters
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rom_read_arbiter_if slave modport (requests, responses, ROM port, busy)
module rom_read_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    rom_read_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  gnt_q;
    logic                  last_q;
    logic                  rsp0_q;
    logic                  rsp1_q;
    logic                  gnt_d;
    logic                  any_v;
    logic                  idle;
    logic                  rsp_hit;

    always_comb begin
        any_v   = bus.req0_valid | bus.req1_valid;
        // On a tie the requester that did not win last time gets the grant
        gnt_d   = (bus.req0_valid & bus.req1_valid) ? ~last_q : bus.req1_valid;
        idle    = state_q == IDLE;
        // Only the granted requester's ready can retire the response
        rsp_hit = gnt_q ? bus.rsp1_ready : bus.rsp0_ready;
    end

    assign bus.req0_ready = idle & any_v & ~gnt_d;
    assign bus.req1_ready = idle & any_v & gnt_d;
    assign bus.rsp0_valid = rsp0_q;
    assign bus.rsp1_valid = rsp1_q;
    assign bus.rsp_data   = data_q;
    assign bus.rom_addr   = addr_q;
    assign bus.busy       = ~idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            rsp0_q  <= 1'b0;
            rsp1_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (any_v) begin
                    addr_q  <= gnt_d ? bus.req1_addr : bus.req0_addr;
                    gnt_q   <= gnt_d;
                    state_q <= READ;
                end
                READ: begin
                    data_q  <= bus.rom_data;
                    rsp0_q  <= ~gnt_q;
                    rsp1_q  <= gnt_q;
                    state_q <= RESP;
                end
                RESP: if (rsp_hit) begin
                    rsp0_q  <= 1'b0;
                    rsp1_q  <= 1'b0;
                    last_q  <= gnt_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
